// File: rtl/acos_taylor_2.sv
// acos_taylor_2: acos(x) ~= pi/2 - x - x^3/6 for IEEE-754 single x, using one
// shared multiplier and one shared adder that are sequenced by an FSM.
// Ports:
//   clk, rst            clock and synchronous active-high reset (also resets fp units)
//   x, x_stb, x_ack     operand in (stb/ack handshake)
//   acos, acos_stb, acos_ack  result out (stb/ack handshake; held until acknowledged)
// fp_mult2x32 / fp_adder_2x32: stb/ack float units. Denormals are flushed to zero
// and rounding is to nearest-even. Inf/NaN operands never reach them here because
// the domain check diverts |x|>1.

module fp_mult2x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [1:0] {GET_A, GET_B, CALC, PUT_Z} state_t;
    state_t state;
    logic [31:0] a_r, b_r, z_c;
    logic [47:0] prod;
    logic signed [9:0] e;
    logic [24:0] mr;
    logic g, s, sign;

    always_comb begin
        prod = {1'b1, a_r[22:0]} * {1'b1, b_r[22:0]};
        e    = $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127;
        sign = a_r[31] ^ b_r[31];
        if (prod[47]) begin
            mr = {1'b0, prod[47:24]};
            g  = prod[23];
            s  = |prod[22:0];
            e  = e + 10'sd1;
        end else begin
            mr = {1'b0, prod[46:23]};
            g  = prod[22];
            s  = |prod[21:0];
        end
        if (g && (s || mr[0])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (a_r[30:23] == 8'd0 || b_r[30:23] == 8'd0 || e <= 10'sd0)
            z_c = {sign, 31'd0};
        else if (e >= 10'sd255)
            z_c = {sign, 8'hFF, 23'd0};
        else
            z_c = {sign, e[7:0], mr[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            a_r          <= '0;
            b_r          <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_stb && input_a_ack) begin
                        a_r         <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_stb && input_b_ack) begin
                        b_r         <= input_b;
                        input_b_ack <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    output_z     <= z_c;
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end
endmodule

module fp_adder_2x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [1:0] {GET_A, GET_B, CALC, PUT_Z} state_t;
    state_t state;
    logic [31:0] a_r, b_r, z_c, big, sml;
    logic [7:0] d;
    logic [50:0] mx, my, sum, norm;
    logic signed [9:0] e;
    logic [24:0] mr;
    logic g, s, az, bz;
    int unsigned k;

    always_comb begin
        az = (a_r[30:23] == 8'd0);
        bz = (b_r[30:23] == 8'd0);
        if (a_r[30:0] >= b_r[30:0]) begin
            big = a_r;
            sml = b_r;
        end else begin
            big = b_r;
            sml = a_r;
        end
        d  = big[30:23] - sml[30:23];
        // Leading bit sits at 49; 26 spare low bits keep alignment exact up to d=25.
        // Beyond that the smaller operand only matters as a sticky bit.
        mx = {2'b01, big[22:0], 26'd0};
        my = (d > 8'd25) ? 51'd1 : ({2'b01, sml[22:0], 26'd0} >> d);
        sum = (big[31] == sml[31]) ? (mx + my) : (mx - my);
        k = 0;
        for (int unsigned i = 0; i < 51; i++)
            if (sum[i[5:0]]) k = i;
        norm = sum << (50 - k);
        e  = $signed({2'b00, big[30:23]} + k[9:0] - 10'd49);
        mr = {1'b0, norm[50:27]};
        g  = norm[26];
        s  = |norm[25:0];
        if (g && (s || mr[0])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (az && bz)
            z_c = {a_r[31] & b_r[31], 31'd0};
        else if (az)
            z_c = b_r;
        else if (bz)
            z_c = a_r;
        else if (sum == 51'd0 || e <= 10'sd0)
            z_c = (sum == 51'd0) ? 32'd0 : {big[31], 31'd0};
        else if (e >= 10'sd255)
            z_c = {big[31], 8'hFF, 23'd0};
        else
            z_c = {big[31], e[7:0], mr[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            a_r          <= '0;
            b_r          <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_stb && input_a_ack) begin
                        a_r         <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_stb && input_b_ack) begin
                        b_r         <= input_b;
                        input_b_ack <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    output_z     <= z_c;
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end
endmodule

module acos_taylor_2 #(
    parameter logic [31:0] PI_HALF = 32'h3FC90FDB,
    parameter logic [31:0] C3      = 32'h3E2AAAAB,
    parameter logic [31:0] QNAN    = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        x_stb,
    output logic        x_ack,
    output logic [31:0] acos,
    output logic        acos_stb,
    input  logic        acos_ack
);
    typedef enum logic [2:0] {IDLE, CHECK, MUL_LD, MUL_WT, ADD_LD, ADD_WT, DONE} state_t;
    state_t state;
    logic [31:0] xr, op_a, op_b, mul_z, add_z;
    logic [2:0]  step;
    logic mul_a_stb, mul_b_stb, mul_z_ack, mul_a_ack, mul_b_ack, mul_z_stb;
    logic add_a_stb, add_b_stb, add_z_ack, add_a_ack, add_b_ack, add_z_stb;

    fp_mult2x32 u_mul (
        .clk(clk), .rst(rst),
        .input_a(op_a), .input_a_stb(mul_a_stb), .input_a_ack(mul_a_ack),
        .input_b(op_b), .input_b_stb(mul_b_stb), .input_b_ack(mul_b_ack),
        .output_z(mul_z), .output_z_stb(mul_z_stb), .output_z_ack(mul_z_ack)
    );

    fp_adder_2x32 u_add (
        .clk(clk), .rst(rst),
        .input_a(op_a), .input_a_stb(add_a_stb), .input_a_ack(add_a_ack),
        .input_b(op_b), .input_b_stb(add_b_stb), .input_b_ack(add_b_ack),
        .output_z(add_z), .output_z_stb(add_z_stb), .output_z_ack(add_z_ack)
    );

    // Each capture launches the next step directly, so the running product p
    // lives only on the op_a/op_b operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_ack     <= 1'b0;
            acos      <= '0;
            acos_stb  <= 1'b0;
            xr        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            step      <= '0;
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b0;
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
        end else begin
            mul_z_ack <= 1'b0;
            add_z_ack <= 1'b0;
            case (state)
                IDLE: begin
                    x_ack <= 1'b1;
                    if (x_stb && x_ack) begin
                        xr    <= x;
                        x_ack <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (xr[30:0] > 31'h3F800000) begin
                        acos     <= QNAN;
                        acos_stb <= 1'b1;
                        state    <= DONE;
                    end else begin
                        step      <= 3'd0;
                        op_a      <= xr;
                        op_b      <= xr;
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                        state     <= MUL_LD;
                    end
                end
                MUL_LD: begin
                    if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
                    if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
                    if (!mul_a_stb && !mul_b_stb) state <= MUL_WT;
                end
                MUL_WT: begin
                    if (mul_z_stb) begin
                        mul_z_ack <= 1'b1;
                        step      <= step + 3'd1;
                        if (step == 3'd2) begin
                            op_a      <= xr;
                            op_b      <= mul_z;
                            add_a_stb <= 1'b1;
                            add_b_stb <= 1'b1;
                            state     <= ADD_LD;
                        end else begin
                            op_a      <= mul_z;
                            op_b      <= (step == 3'd0) ? xr : C3;
                            mul_a_stb <= 1'b1;
                            mul_b_stb <= 1'b1;
                            state     <= MUL_LD;
                        end
                    end
                end
                ADD_LD: begin
                    if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
                    if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
                    if (!add_a_stb && !add_b_stb) state <= ADD_WT;
                end
                ADD_WT: begin
                    if (add_z_stb) begin
                        add_z_ack <= 1'b1;
                        step      <= step + 3'd1;
                        if (step == 3'd3) begin
                            op_a      <= PI_HALF;
                            op_b      <= {~add_z[31], add_z[30:0]};
                            add_a_stb <= 1'b1;
                            add_b_stb <= 1'b1;
                            state     <= ADD_LD;
                        end else begin
                            acos     <= add_z;
                            acos_stb <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (acos_ack) begin
                        acos_stb <= 1'b0;
                        x_ack    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acos_taylor_2.sv
// tb_acos_taylor_2: directed bench for acos_taylor_2 (reset, in-domain values,
// domain boundaries, out-of-domain QNAN timing, backpressure, reset mid-operation).
module tb_acos_taylor_2;
    localparam logic [31:0] PI_HALF = 32'h3FC90FDB;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x = '0;
    logic        x_stb = 1'b0;
    logic        x_ack;
    logic [31:0] acos;
    logic        acos_stb;
    logic        acos_ack = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    acos_taylor_2 dut (
        .clk(clk), .rst(rst),
        .x(x), .x_stb(x_stb), .x_ack(x_ack),
        .acos(acos), .acos_stb(acos_stb), .acos_ack(acos_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp, input int unsigned tol = 0);
        int unsigned diff;
        n_checks++;
        diff = (obs > exp) ? obs - exp : exp - obs;
        if ((^obs) === 1'bx || diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Present v and return just after the accepting edge.
    task automatic send(input logic [31:0] v);
        int unsigned n = 0;
        @(negedge clk);
        x = v;
        x_stb = 1'b1;
        while (!x_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("x_ack_wait", {31'd0, x_ack}, 32'd1);
        @(posedge clk);
        #1 x_stb = 1'b0;
    endtask

    task automatic wait_result;
        int unsigned n = 0;
        while (!acos_stb && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("result_timeout", {31'd0, acos_stb}, 32'd1);
    endtask

    task automatic do_ack;
        @(negedge clk);
        acos_ack = 1'b1;
        @(posedge clk);
        #1 acos_ack = 1'b0;
        check_eq("stb_after_ack", {31'd0, acos_stb}, 32'd0);
        check_eq("x_ack_after_ack", {31'd0, x_ack}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v,
                           input logic [31:0] exp, input int unsigned tol);
        send(v);
        wait_result();
        check_eq(tag, acos, exp, tol);
        do_ack();
    endtask

    initial begin
        int unsigned n;
        logic [31:0] held;

        repeat (3) @(negedge clk);
        check_eq("rst_x_ack", {31'd0, x_ack}, 32'd0);
        check_eq("rst_acos", acos, 32'd0);
        check_eq("rst_acos_stb", {31'd0, acos_stb}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("x_ack_after_rst", {31'd0, x_ack}, 32'd1);

        // x=0: result held until acknowledged.
        send(32'h00000000);
        wait_result();
        for (int i = 0; i < 3; i++) begin
            check_eq("zero_val", acos, PI_HALF);
            check_eq("zero_stb_held", {31'd0, acos_stb}, 32'd1);
            @(negedge clk);
        end
        do_ack();

        // Expected values: float pipeline pi/2 - (x + x*x*x*C3), RNE each step.
        // 0.5  -> 17615457*2^-24 ties to even -> 0x3F866530 (1.0499630)
        // -0.5 -> 35091723*2^-24 rounds up    -> 0x4005DD43 (2.0916297)
        // 1.0  -> (13176795-9786709)*2^-23 exact -> 0x3ECEEA18 (0.4041297)
        // -1.0 -> (13176795+9786709)*2^-23 exact -> 0x402F3298 (2.7374630)
        run_vec("neg_zero", 32'h80000000, PI_HALF, 0);
        run_vec("half", 32'h3F000000, 32'h3F866530, 2);
        run_vec("neg_half", 32'hBF000000, 32'h4005DD43, 2);
        run_vec("one", 32'h3F800000, 32'h3ECEEA18, 2);
        run_vec("neg_one", 32'hBF800000, 32'h402F3298, 2);
        run_vec("above_one", 32'h3F800001, QNAN, 0);
        run_vec("inf", 32'h7F800000, QNAN, 0);
        run_vec("neg_nan", 32'hFFC00000, QNAN, 0);

        // 1.5: QNAN valid exactly two cycles after the accept cycle.
        send(32'h3FC00000);
        check_eq("oob_stb_early", {31'd0, acos_stb}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("oob_stb_2cyc", {31'd0, acos_stb}, 32'd1);
        check_eq("oob_val", acos, QNAN);
        do_ack();

        // Backpressure in DONE with x_stb pulses.
        send(32'h3F000000);
        wait_result();
        held = acos;
        check_eq("bp_first", held, 32'h3F866530, 2);
        for (int i = 0; i < 10; i++) begin
            x = 32'h3FC00000;
            x_stb = (i % 2 == 0);
            @(negedge clk);
            check_eq("bp_val", acos, held);
            check_eq("bp_stb", {31'd0, acos_stb}, 32'd1);
            check_eq("bp_x_ack", {31'd0, x_ack}, 32'd0);
        end
        x_stb = 1'b0;
        do_ack();

        // Reset for one cycle during step 2.
        send(32'h3F000000);
        n = 0;
        while (dut.step != 3'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_step2", {29'd0, dut.step}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_stb", {31'd0, acos_stb}, 32'd0);
        check_eq("mid_rst_acos", acos, 32'd0);
        check_eq("mid_rst_x_ack", {31'd0, x_ack}, 32'd0);
        @(negedge clk);
        check_eq("mid_rst_x_ack_up", {31'd0, x_ack}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("no_stale_stb", {31'd0, acos_stb}, 32'd0);
            @(negedge clk);
        end
        send(32'h00000000);
        check_eq("follow_no_spurious", {31'd0, acos_stb}, 32'd0);
        wait_result();
        check_eq("follow_val", acos, PI_HALF);
        do_ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
